// File: rtl/vend_pkg.sv
// Shared types, default widths and helpers for the vending payment controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_RETURN   = 2'd3
    } state_e;

    localparam int DEF_N_ITEMS  = 4;
    localparam int DEF_PRICE_W  = 4;
    localparam int DEF_CREDIT_W = 6;
    localparam int DEF_STOCK_W  = 4;
    localparam int DEF_TIMEOUT  = 200;

    // a + b clamped to max_val; callers zero-extend narrower operands to 32 bits
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with restock (saturating), dispense decrement and a read port.
// Latency: updates visible the cycle after the strobe; read port is combinational off the registers.
// Backpressure: none; every strobe is applied, out-of-range restock indices match no slot.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int N_ITEMS = DEF_N_ITEMS,
    parameter int STOCK_W = DEF_STOCK_W,
    parameter int IDX_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restock_valid,
    input  logic [IDX_W-1:0]   restock_idx,
    input  logic [STOCK_W-1:0] restock_cnt,
    input  logic               dec_valid,
    input  logic [IDX_W-1:0]   dec_idx,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [STOCK_W-1:0] rd_cnt
);

    localparam logic [31:0] STOCK_MAX = 32'((1 << STOCK_W) - 1);

    logic [STOCK_W-1:0] cnt_q [N_ITEMS];
    logic [STOCK_W-1:0] cnt_d [N_ITEMS];

    // Net update per slot: take the dispensed unit first, then add the restock with saturation,
    // so a coincident decrement and restock land on old - 1 + cnt clamped to STOCK_MAX.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (dec_valid && (dec_idx == IDX_W'(i)) && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - STOCK_W'(1);
            end
            if (restock_valid && (restock_idx == IDX_W'(i))) begin
                cnt_d[i] = STOCK_W'(sat_add(32'(cnt_d[i]), 32'(restock_cnt), STOCK_MAX));
            end
        end
    end

    // Counter registers, all slots empty out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rd_cnt = (32'(rd_idx) < 32'(N_ITEMS)) ? cnt_q[rd_idx] : '0;

endmodule

// File: rtl/vend_payment_ctrl.sv
// Multi-item vending payment controller: selection, coin collection, timeout/cancel refund, dispense, change.
// Latency: paying coin -> dispense_valid 2 cycles later -> change_valid 1 cycle after that; all outputs registered.
// Backpressure: none; coins that cannot be taken are bounced with coin_reject, selections while busy are dropped.
module vend_payment_ctrl
    import vend_pkg::*;
#(
    parameter int  N_ITEMS  = DEF_N_ITEMS,
    parameter int  PRICE_W  = DEF_PRICE_W,
    parameter int  CREDIT_W = DEF_CREDIT_W,
    parameter int  STOCK_W  = DEF_STOCK_W,
    parameter int  TIMEOUT  = DEF_TIMEOUT,
    localparam int IDX_W    = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel_valid,
    input  logic [IDX_W-1:0]    sel_idx,
    input  logic [PRICE_W-1:0]  price,
    input  logic                coin_valid,
    input  logic [PRICE_W-1:0]  coin_value,
    input  logic                cancel,
    input  logic                restock_valid,
    input  logic [IDX_W-1:0]    restock_idx,
    input  logic [STOCK_W-1:0]  restock_cnt,
    output logic                busy,
    output logic                dispense_valid,
    output logic [IDX_W-1:0]    dispense_idx,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_value,
    output logic                coin_reject,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    // Timer hits TIMEOUT-1 on the same edge that moves to RETURN, so compare against one less.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);

    state_e              state;
    logic [IDX_W-1:0]    idx_q;
    logic [PRICE_W-1:0]  price_q;
    logic [TMR_W-1:0]    timer;
    logic [CREDIT_W-1:0] amount;
    logic [STOCK_W-1:0]  sel_stock;
    logic [CREDIT_W:0]   coin_sum;
    logic                sel_ok;
    logic                paid;

    assign coin_sum = {1'b0, credit} + (CREDIT_W + 1)'(coin_value);
    assign sel_ok   = sel_valid && (32'(sel_idx) < 32'(N_ITEMS));
    assign paid     = credit >= CREDIT_W'(price_q);

    vend_stock_bank #(
        .N_ITEMS (N_ITEMS),
        .STOCK_W (STOCK_W),
        .IDX_W   (IDX_W)
    ) u_stock (
        .clk           (clk),
        .rst_n         (rst_n),
        .restock_valid (restock_valid),
        .restock_idx   (restock_idx),
        .restock_cnt   (restock_cnt),
        .dec_valid     (state == ST_DISPENSE),
        .dec_idx       (idx_q),
        .rd_idx        (sel_idx),
        .rd_cnt        (sel_stock)
    );

    // Transaction FSM with credit, timer and registered output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx_q          <= '0;
            price_q        <= '0;
            timer          <= '0;
            amount         <= '0;
            busy           <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_idx   <= '0;
            change_valid   <= 1'b0;
            change_value   <= '0;
            coin_reject    <= 1'b0;
            sold_out       <= 1'b0;
            credit         <= '0;
        end else begin
            dispense_valid <= 1'b0;
            change_valid   <= 1'b0;
            coin_reject    <= 1'b0;
            sold_out       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    coin_reject <= coin_valid;
                    if (sel_ok) begin
                        if (sel_stock == '0) begin
                            sold_out <= 1'b1;
                        end else begin
                            idx_q   <= sel_idx;
                            price_q <= price;
                            credit  <= '0;
                            timer   <= '0;
                            busy    <= 1'b1;
                            state   <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    // Once paid the sale is committed: cancel is moot and further coins bounce.
                    if (paid) begin
                        coin_reject <= coin_valid;
                        state       <= ST_DISPENSE;
                    end else if (cancel) begin
                        coin_reject <= coin_valid;
                        amount      <= credit;
                        state       <= ST_RETURN;
                    end else if (coin_valid && !coin_sum[CREDIT_W]) begin
                        credit <= coin_sum[CREDIT_W-1:0];
                        timer  <= '0;
                    end else begin
                        coin_reject <= coin_valid;
                        if (timer == TMR_LAST) begin
                            amount <= credit;
                            state  <= ST_RETURN;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end
                ST_DISPENSE: begin
                    coin_reject    <= coin_valid;
                    dispense_valid <= 1'b1;
                    dispense_idx   <= idx_q;
                    amount         <= credit - CREDIT_W'(price_q);
                    if (credit != CREDIT_W'(price_q)) begin
                        state <= ST_RETURN;
                    end else begin
                        credit <= '0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_RETURN: begin
                    coin_reject  <= coin_valid;
                    change_valid <= 1'b1;
                    change_value <= amount;
                    credit       <= '0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_payment_ctrl.sv
// Self-checking bench: directed scenarios then random traffic against a session/event-schedule model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vend_payment_ctrl;

    localparam int N  = 4;
    localparam int PW = 6;
    localparam int CW = 6;
    localparam int SW = 4;
    localparam int TO = 10;
    localparam int CREDIT_MAX = (1 << CW) - 1;
    localparam int STOCK_MAX  = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel_valid = 1'b0;
    logic [1:0]    sel_idx = '0;
    logic [PW-1:0] price = '0;
    logic          coin_valid = 1'b0;
    logic [PW-1:0] coin_value = '0;
    logic          cancel = 1'b0;
    logic          restock_valid = 1'b0;
    logic [1:0]    restock_idx = '0;
    logic [SW-1:0] restock_cnt = '0;
    logic          busy, dispense_valid, change_valid, coin_reject, sold_out;
    logic [1:0]    dispense_idx;
    logic [CW-1:0] change_value, credit;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Reference model: an open session plus a schedule of future events
    int m_stock [N];
    bit m_open;
    int m_idx, m_price, m_credit, m_last;
    int m_disp_at, m_disp_idx, m_chg_at, m_chg_val, m_clear_at, m_idle_from;
    int m_disp_hold, m_chg_hold;
    bit e_rej, e_sold, e_busy, e_disp, e_chg;

    always #5 clk = ~clk;

    vend_payment_ctrl #(
        .N_ITEMS(N), .PRICE_W(PW), .CREDIT_W(CW), .STOCK_W(SW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .price(price),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
        .restock_valid(restock_valid), .restock_idx(restock_idx), .restock_cnt(restock_cnt),
        .busy(busy), .dispense_valid(dispense_valid), .dispense_idx(dispense_idx),
        .change_valid(change_valid), .change_value(change_value),
        .coin_reject(coin_reject), .sold_out(sold_out), .credit(credit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_stock[i] = 0;
        m_open = 0; m_idx = 0; m_price = 0; m_credit = 0; m_last = 0;
        m_disp_at = -1; m_disp_idx = 0; m_chg_at = -1; m_chg_val = 0;
        m_clear_at = -1; m_idle_from = 0; m_disp_hold = 0; m_chg_hold = 0;
        e_rej = 0; e_sold = 0; e_busy = 0; e_disp = 0; e_chg = 0;
    endtask

    task automatic refund();
        m_open = 0;
        m_chg_at = n + 1; m_chg_val = m_credit;
        m_clear_at = n + 1; m_idle_from = n + 2;
    endtask

    // Applies the rules to the inputs sampled at edge n; sets expectations for just after it
    task automatic model_step();
        int amt;
        int v;
        bit accepted;
        e_rej = 0; e_sold = 0;
        if (n == m_clear_at) m_credit = 0;
        if (m_open) begin
            if (m_credit >= m_price) begin
                e_rej = coin_valid;
                amt = m_credit - m_price;
                m_open = 0;
                m_disp_at = n + 1; m_disp_idx = m_idx;
                if (amt > 0) begin
                    m_chg_at = n + 2; m_chg_val = amt; m_clear_at = n + 2; m_idle_from = n + 3;
                end else begin
                    m_clear_at = n + 1; m_idle_from = n + 2;
                end
            end else if (cancel) begin
                e_rej = coin_valid;
                refund();
            end else begin
                accepted = 0;
                if (coin_valid) begin
                    if (m_credit + int'(coin_value) > CREDIT_MAX) e_rej = 1;
                    else begin
                        m_credit += int'(coin_value); m_last = n; accepted = 1;
                    end
                end
                if (!accepted && (n - m_last == TO - 1)) refund();
            end
        end else begin
            e_rej = coin_valid;
            if (n >= m_idle_from && sel_valid && int'(sel_idx) < N) begin
                if (m_stock[sel_idx] == 0) e_sold = 1;
                else begin
                    m_open = 1; m_idx = int'(sel_idx); m_price = int'(price);
                    m_credit = 0; m_last = n;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            v = m_stock[i];
            if (n == m_disp_at && m_disp_idx == i) v = v - 1;
            if (restock_valid && int'(restock_idx) == i) v = v + int'(restock_cnt);
            m_stock[i] = (v > STOCK_MAX) ? STOCK_MAX : v;
        end
        e_disp = (n == m_disp_at);
        e_chg  = (n == m_chg_at);
        if (e_disp) m_disp_hold = m_disp_idx;
        if (e_chg)  m_chg_hold = m_chg_val;
        e_busy = m_open || (n < m_idle_from - 1);
    endtask

    task automatic check_all();
        chk("busy", 32'(busy), 32'(e_busy));
        chk("credit", 32'(credit), 32'(m_credit));
        chk("dispense_valid", 32'(dispense_valid), 32'(e_disp));
        chk("dispense_idx", 32'(dispense_idx), 32'(m_disp_hold));
        chk("change_valid", 32'(change_valid), 32'(e_chg));
        chk("change_value", 32'(change_value), 32'(m_chg_hold));
        chk("coin_reject", 32'(coin_reject), 32'(e_rej));
        chk("sold_out", 32'(sold_out), 32'(e_sold));
        for (int i = 0; i < N; i++)
            chk($sformatf("stock%0d", i), 32'(dut.u_stock.cnt_q[i]), 32'(m_stock[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        n++;
        #1;
        if (rst_n) check_all();
        @(negedge clk);
        sel_valid = 0; coin_valid = 0; cancel = 0; restock_valid = 0;
    endtask

    task automatic do_sel(input int idx, input int p);
        sel_valid = 1; sel_idx = 2'(idx); price = PW'(p); tick();
    endtask

    task automatic do_coin(input int val);
        coin_valid = 1; coin_value = PW'(val); tick();
    endtask

    task automatic do_restock(input int idx, input int cnt);
        restock_valid = 1; restock_idx = 2'(idx); restock_cnt = SW'(cnt); tick();
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_pulses", 32'({dispense_valid, change_valid, coin_reject, sold_out}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // Purchase with change
        do_restock(2, 5);
        do_sel(2, 7);
        do_coin(5); chk("tp1_credit5", 32'(credit), 32'd5);
        do_coin(5); chk("tp1_credit10", 32'(credit), 32'd10);
        tick();
        tick(); chk("tp1_disp", 32'(dispense_valid), 32'd1); chk("tp1_disp_idx", 32'(dispense_idx), 32'd2);
        tick(); chk("tp1_chg", 32'(change_valid), 32'd1); chk("tp1_chg_val", 32'(change_value), 32'd3);
        chk("tp1_stock2", 32'(dut.u_stock.cnt_q[2]), 32'd4);

        // Sold out then idle coin
        do_sel(1, 5); chk("tp2_sold_out", 32'(sold_out), 32'd1); chk("tp2_busy", 32'(busy), 32'd0);
        do_coin(3); chk("tp2_coin_rej", 32'(coin_reject), 32'd1);

        // Cancel with a coincident coin
        do_sel(2, 9);
        do_coin(4);
        cancel = 1; coin_valid = 1; coin_value = PW'(2); tick();
        chk("tp3_coin_rej", 32'(coin_reject), 32'd1);
        tick(); chk("tp3_chg", 32'(change_valid), 32'd1); chk("tp3_chg_val", 32'(change_value), 32'd4);
        chk("tp3_idle", 32'(busy), 32'd0);

        // Timeout refund ten cycles after the last coin
        do_sel(2, 9);
        do_coin(3);
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO) begin
                chk("tp4_chg", 32'(change_valid), 32'd1); chk("tp4_chg_val", 32'(change_value), 32'd3);
            end
        end

        // Credit overflow bounce, then exact payment with no change
        do_sel(2, 63);
        do_coin(20); do_coin(20); do_coin(20);
        do_coin(5); chk("tp5_rej", 32'(coin_reject), 32'd1); chk("tp5_credit60", 32'(credit), 32'd60);
        do_coin(3); chk("tp5_credit63", 32'(credit), 32'd63);
        tick();
        tick(); chk("tp5_disp", 32'(dispense_valid), 32'd1); chk("tp5_no_busy", 32'(busy), 32'd0);
        tick(); chk("tp5_no_chg", 32'(change_valid), 32'd0);

        // Saturated stock with a restock landing on the dispense cycle
        do_restock(0, 15);
        do_sel(0, 0);
        tick();
        do_restock(0, 3); chk("tp6_disp", 32'(dispense_valid), 32'd1);
        chk("tp6_stock0", 32'(dut.u_stock.cnt_q[0]), 32'd15);

        // Reset in the middle of collecting
        do_sel(2, 50);
        do_coin(6); chk("tp7_credit6", 32'(credit), 32'd6);
        rst_n = 0;
        #2;
        chk("tp7_busy", 32'(busy), 32'd0);
        chk("tp7_credit", 32'(credit), 32'd0);
        chk("tp7_stock0", 32'(dut.u_stock.cnt_q[0]), 32'd0);
        model_reset();
        tick(); tick();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            tick(); chk("tp7_no_chg", 32'(change_valid), 32'd0);
        end

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            sel_valid     = ($urandom_range(0, 9) == 0);
            sel_idx       = 2'($urandom_range(0, N - 1));
            price         = PW'($urandom_range(0, 63));
            coin_valid    = ($urandom_range(0, 2) == 0);
            coin_value    = PW'($urandom_range(0, 20));
            cancel        = ($urandom_range(0, 29) == 0);
            restock_valid = ($urandom_range(0, 15) == 0);
            restock_idx   = 2'($urandom_range(0, N - 1));
            restock_cnt   = SW'($urandom_range(0, STOCK_MAX));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_payment_ctrl.md
Name: vend_payment_ctrl

Overview:
- Parametrised successor of the single-price Customer block: multi-item payment and dispense controller for the vending machine.
- Handles item selection against per-item stock, coin accumulation, timeout and cancel refunds, dispensing and change return.
- Sits between the coin/keypad front end and the dispenser/change actuators.
- All outputs are registered.

Parameters:
- N_ITEMS, 4, number of product slots; IDX_W = $clog2(N_ITEMS), minimum 1.
- PRICE_W, 4, price width in coin units.
- CREDIT_W, 6, credit accumulator width; must satisfy CREDIT_W >= PRICE_W.
- STOCK_W, 4, per-item stock counter width; STOCK_MAX = 2^STOCK_W - 1.
- TIMEOUT, 200, idle cycles in COLLECT before an automatic refund; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sel_valid  in  1  item selection strobe.
- sel_idx  in  IDX_W  selected item.
- price  in  PRICE_W  price of sel_idx; sampled only with an accepted sel_valid.
- coin_valid  in  1  coin-inserted strobe.
- coin_value  in  PRICE_W  coin value.
- cancel  in  1  customer cancel request.
- restock_valid  in  1  restock strobe.
- restock_idx  in  IDX_W  item to restock.
- restock_cnt  in  STOCK_W  units added.
- busy  out  1  high when state != IDLE.
- dispense_valid  out  1  one-cycle dispense pulse.
- dispense_idx  out  IDX_W  item dispensed.
- change_valid  out  1  one-cycle change/refund pulse.
- change_value  out  CREDIT_W  amount returned.
- coin_reject  out  1  one-cycle pulse: the coin was not accepted and is returned.
- sold_out  out  1  one-cycle pulse: selection refused because stock is 0.
- credit  out  CREDIT_W  current accumulated credit.

Behaviour:
- Reset: all outputs 0, state IDLE, every stock counter 0, internal timer 0.
- Reset is asynchronous, active-low. Asserting it mid-transaction discards credit with no change pulse.
- States: IDLE, COLLECT, DISPENSE, RETURN.
- IDLE:
  - sel_valid with sel_idx >= N_ITEMS: ignored.
  - sel_valid with stock[sel_idx] == 0: sold_out pulses next cycle; stay IDLE.
  - Otherwise: latch idx and price, credit = 0, timer = 0, go to COLLECT.
  - coin_valid in IDLE: coin_reject pulses.
- COLLECT:
  - Priority order: cancel, then coin, then timeout.
  - cancel: go to RETURN with amount = credit. A coin in the same cycle is rejected.
  - coin_valid: if credit + coin_value > 2^CREDIT_W - 1, pulse coin_reject and leave credit unchanged. Otherwise add coin_value to credit and reset timer to 0.
  - Timer increments every cycle with no accepted coin. At timer == TIMEOUT - 1, go to RETURN with amount = credit.
  - When the registered credit >= latched price, go to DISPENSE on the next edge. A latched price of 0 reaches DISPENSE one cycle after selection.
  - sel_valid is ignored while busy.
- DISPENSE (exactly 1 cycle):
  - dispense_valid = 1, dispense_idx = latched idx.
  - stock[idx] decrements by 1.
  - amount = credit - price.
  - If amount != 0, go to RETURN; otherwise go to IDLE with credit cleared.
- RETURN (exactly 1 cycle):
  - change_valid = 1, change_value = amount, credit cleared, go to IDLE.
  - A refund with amount 0 still pulses change_valid, with change_value = 0.
- Restock:
  - Accepted in any state: stock[restock_idx] += restock_cnt, saturating at STOCK_MAX.
  - Ignored if restock_idx >= N_ITEMS.
  - If it coincides with a DISPENSE decrement on the same item, apply the net value: old - 1 + cnt, saturated.
- Latency: a coin that completes payment produces dispense_valid 2 cycles after the coin_valid edge, and change_valid 1 cycle after that.

Decomposition:
- Package vend_pkg holds:
  - state encoding enum (IDLE=0, COLLECT=1, DISPENSE=2, RETURN=3);
  - default widths;
  - a saturating-add function.
- Sub-module vend_stock_bank: N_ITEMS × STOCK_W counters with restock port, decrement port and read port, including the saturation and net-update rules.
- The FSM, credit register and timer stay in the top module.

Test Plan:
- Restock item 2 with 5. Select idx 2, price 7. Insert coins 5 and then 5. Expect: credit reads 5 then 10; dispense_valid with idx 2; next cycle change_valid with value 3; stock[2] = 4.
- Select item 1 while its stock is 0. Expect: sold_out pulse, busy stays 0, and a coin inserted afterwards gives coin_reject.
- Select price 9, insert 4, then assert cancel and coin_valid in the same cycle. Expect: coin_reject, then change_valid with value 4, then IDLE.
- TIMEOUT = 10: select, insert 3, then hold all inputs idle. Expect change_valid with value 3 exactly 10 cycles after the coin edge.
- Credit 60 with CREDIT_W = 6: insert coin 5. Expect coin_reject and credit held at 60.
- Stock 15 on item 0 (saturated), and restock 3 during the DISPENSE cycle of item 0. Expect stock 15. Separately, assert rst_n = 0 in COLLECT with credit 6: outputs clear immediately and no change pulse occurs.
